// File: rtl/barrido_pkg.sv
// Shared definitions for the round-robin channel scanner: FSM encodings,
// channel count and the pointer reset value.
package barrido_pkg;

    typedef enum logic {
        REPOSO = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    localparam int N_CANALES = 4;

    // Pointer starts at the last channel so the first search wraps to channel 0.
    localparam logic [1:0] PTR_RESET = 2'd3;

endpackage

// File: rtl/barrido_mux4_siguiente_canal.sv
// Wrap-around priority search: lowest enabled channel strictly after ptr,
// falling back to ptr itself when it is the only enabled channel.
module siguiente_canal
    import barrido_pkg::*;
(
    input  logic [1:0]           ptr,
    input  logic [N_CANALES-1:0] mascara,
    output logic [1:0]           sig,
    output logic                 hay
);

    // cand[k] is the channel k positions after ptr, modulo 4.
    logic [1:0] cand [1:N_CANALES-1];

    generate
        for (genvar gi = 1; gi < N_CANALES; gi++) begin : g_cand
            assign cand[gi] = ptr + 2'(gi);
        end
    endgenerate

    // Scan from the farthest candidate to the nearest so the nearest enabled one wins.
    always_comb begin
        sig = ptr;
        for (int k = N_CANALES - 1; k >= 1; k--) begin
            if (mascara[cand[k]]) begin
                sig = cand[k];
            end
        end
        hay = |mascara;
    end

endmodule

// File: rtl/mux4a1.sv
// Combinational 4:1 channel multiplexer driven by the scanner's select lines.
module mux4a1 #(
    parameter int width = 4
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic [width-1:0] C,
    input  logic [width-1:0] D,
    input  logic             s0,
    input  logic             s1,
    output logic [width-1:0] F
);

    // Route the selected channel straight through.
    always_comb begin
        F = A;
        case ({s1, s0})
            2'b00:   F = A;
            2'b01:   F = B;
            2'b10:   F = C;
            default: F = D;
        endcase
    end

endmodule

// File: rtl/barrido_mux4.sv
// Round-robin scanner: steps the mux select through the enabled channels,
// dwells a programmable number of cycles on each, and captures the mux
// output tagged with its channel index plus a one-cycle valid strobe.
module barrido_mux4
    import barrido_pkg::*;
#(
    parameter int ancho   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [3:0]         mascara,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ancho-1:0]   F_in,
    output logic               s0,
    output logic               s1,
    output logic [ancho-1:0]   dato,
    output logic [1:0]         canal,
    output logic               valido,
    output logic               ocupado
);

    estado_t            state_reg,  state_next;
    logic [1:0]         ptr_reg,    ptr_next;
    logic [DWELL_W-1:0] cnt_reg,    cnt_next;
    logic [1:0]         sel_reg,    sel_next;
    logic [ancho-1:0]   dato_reg,   dato_next;
    logic [1:0]         canal_reg,  canal_next;
    logic               valido_reg, valido_next;

    logic [1:0]         sig;
    logic               hay;
    logic               carga;
    logic [DWELL_W-1:0] dwell_carga;

    siguiente_canal u_siguiente (
        .ptr     (ptr_reg),
        .mascara (mascara),
        .sig     (sig),
        .hay     (hay)
    );

    // A dwell of 0 behaves like 1, so the reload value saturates at zero.
    assign dwell_carga = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= REPOSO;
            ptr_reg    <= PTR_RESET;
            cnt_reg    <= '0;
            sel_reg    <= 2'b00;
            dato_reg   <= '0;
            canal_reg  <= 2'b00;
            valido_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            sel_reg    <= sel_next;
            dato_reg   <= dato_next;
            canal_reg  <= canal_next;
            valido_reg <= valido_next;
        end
    end

    // Next-state: idle start, dwell countdown, capture and back-to-back reselection.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        sel_next    = sel_reg;
        dato_next   = dato_reg;
        canal_next  = canal_reg;
        valido_next = 1'b0;
        carga       = 1'b0;

        case (state_reg)
            REPOSO: begin
                if (en && hay) begin
                    carga = 1'b1;
                end
            end
            ESPERA: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end else begin
                    dato_next   = F_in;
                    canal_next  = sel_reg;
                    valido_next = 1'b1;
                    if (en && hay) begin
                        carga = 1'b1;
                    end else begin
                        state_next = REPOSO;
                        sel_next   = 2'b00;
                    end
                end
            end
            default: begin
                state_next = REPOSO;
                sel_next   = 2'b00;
            end
        endcase

        // Mask and dwell are only looked at here, when a new channel is chosen.
        if (carga) begin
            state_next = ESPERA;
            sel_next   = sig;
            ptr_next   = sig;
            cnt_next   = dwell_carga;
        end
    end

    assign s0      = sel_reg[0];
    assign s1      = sel_reg[1];
    assign dato    = dato_reg;
    assign canal   = canal_reg;
    assign valido  = valido_reg;
    assign ocupado = (state_reg == ESPERA);

endmodule

// File: tb/tb_barrido_mux4.sv
// Directed bench for barrido_mux4 driving a mux4a1 with constant channels
// A..D = 1..4; outputs are sampled on the falling clock edge.
module tb_barrido_mux4;

    localparam int ANCHO = 4;
    localparam int DW    = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [3:0]       mascara;
    logic [DW-1:0]    dwell;
    logic [ANCHO-1:0] ch_a, ch_b, ch_c, ch_d;
    logic [ANCHO-1:0] f_mux;
    logic             s0, s1;
    logic [ANCHO-1:0] dato;
    logic [1:0]       canal;
    logic             valido;
    logic             ocupado;

    int total_cnt;
    int pass_cnt;
    int fail_cnt;

    barrido_mux4 #(.ancho(ANCHO), .DWELL_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mascara (mascara),
        .dwell   (dwell),
        .F_in    (f_mux),
        .s0      (s0),
        .s1      (s1),
        .dato    (dato),
        .canal   (canal),
        .valido  (valido),
        .ocupado (ocupado)
    );

    mux4a1 #(.width(ANCHO)) u_mux (
        .A  (ch_a),
        .B  (ch_b),
        .C  (ch_c),
        .D  (ch_d),
        .s0 (s0),
        .s1 (s1),
        .F  (f_mux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the scanner to return to idle.
    task automatic esperar_reposo(input string tag);
        for (int n = 0; n < 30; n++) begin
            if (!ocupado) break;
            @(negedge clk);
        end
        chk(tag, 8'(ocupado), 8'd0);
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        ch_a = 4'd1; ch_b = 4'd2; ch_c = 4'd3; ch_d = 4'd4;
        rst_n = 1'b0; en = 1'b0; mascara = 4'b0000; dwell = '0;

        // Reset state
        #12;
        chk("rst_sel",     8'({s1, s0}), 8'd0);
        chk("rst_dato",    8'(dato),     8'd0);
        chk("rst_canal",   8'(canal),    8'd0);
        chk("rst_valido",  8'(valido),   8'd0);
        chk("rst_ocupado", 8'(ocupado),  8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all channels, dwell 1 -> continuous samples 1,2,3,4,...
        mascara = 4'b1111; dwell = 8'd1; en = 1'b1;
        @(negedge clk);
        chk("t1_sel0",    8'({s1, s0}), 8'd0);
        chk("t1_ocupado", 8'(ocupado),  8'd1);
        chk("t1_valido0", 8'(valido),   8'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            $display("t1 sample %0d: canal=%0d dato=%0d valido=%0b", i, canal, dato, valido);
            chk("t1_valido", 8'(valido), 8'd1);
            chk("t1_dato",   8'(dato),   8'((i % 4) + 1));
            chk("t1_canal",  8'(canal),  8'(i % 4));
        end
        en = 1'b0;
        @(negedge clk);
        chk("t1_last_canal", 8'(canal),      8'd0);
        chk("t1_last_sel",   8'({s1, s0}),   8'd0);
        chk("t1_idle",       8'(ocupado),    8'd0);
        @(negedge clk);
        chk("t1_novalid",    8'(valido),     8'd0);

        // 2: mascara 1010, dwell 3 -> channels 1/3 alternate, sample every 3 cycles
        mascara = 4'b1010; dwell = 8'd3; en = 1'b1;
        @(negedge clk);
        chk("t2_sel0", 8'({s1, s0}), 8'd1);
        for (int j = 0; j < 4; j++) begin
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                if (k < 3) begin
                    chk("t2_hold_sel", 8'({s1, s0}), (j % 2 == 0) ? 8'd1 : 8'd3);
                    chk("t2_hold_val", 8'(valido),   8'd0);
                end else begin
                    $display("t2 sample %0d: canal=%0d dato=%0d valido=%0b", j, canal, dato, valido);
                    chk("t2_valido", 8'(valido), 8'd1);
                    chk("t2_dato",   8'(dato),   (j % 2 == 0) ? 8'd2 : 8'd4);
                    chk("t2_canal",  8'(canal),  (j % 2 == 0) ? 8'd1 : 8'd3);
                end
            end
        end
        en = 1'b0;
        esperar_reposo("t2_idle_timeout");
        @(negedge clk);

        // 3: dwell 0 on channel 2 only -> behaves as dwell 1
        mascara = 4'b0100; dwell = 8'd0; en = 1'b1;
        @(negedge clk);
        chk("t3_sel0", 8'({s1, s0}), 8'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            $display("t3 sample %0d: canal=%0d dato=%0d valido=%0b", i, canal, dato, valido);
            chk("t3_valido", 8'(valido), 8'd1);
            chk("t3_dato",   8'(dato),   8'd3);
            chk("t3_canal",  8'(canal),  8'd2);
        end
        en = 1'b0;
        esperar_reposo("t3_idle_timeout");
        @(negedge clk);

        // 4: dwell 5 on channel 3, en dropped mid-dwell -> capture still at cycle 5
        mascara = 4'b1000; dwell = 8'd5; en = 1'b1;
        @(negedge clk);
        chk("t4_sel0",    8'({s1, s0}), 8'd3);
        chk("t4_ocupado", 8'(ocupado),  8'd1);
        @(negedge clk);
        en = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("t4_hold_val", 8'(valido),  8'd0);
            chk("t4_hold_ocu", 8'(ocupado), 8'd1);
        end
        @(negedge clk);
        $display("t4 capture: canal=%0d dato=%0d valido=%0b", canal, dato, valido);
        chk("t4_valido",  8'(valido),   8'd1);
        chk("t4_dato",    8'(dato),     8'd4);
        chk("t4_canal",   8'(canal),    8'd3);
        chk("t4_sel_end", 8'({s1, s0}), 8'd0);
        chk("t4_ocu_end", 8'(ocupado),  8'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_after_val", 8'(valido), 8'd0);
            chk("t4_after_dat", 8'(dato),   8'd4);
        end

        // 5: en with empty mask -> stays idle
        mascara = 4'b0000; dwell = 8'd1; en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_valido",  8'(valido),   8'd0);
            chk("t5_ocupado", 8'(ocupado),  8'd0);
            chk("t5_sel",     8'({s1, s0}), 8'd0);
        end
        en = 1'b0;
        @(negedge clk);

        // 6: async reset mid-dwell on channel 2, then restart from channel 0
        mascara = 4'b0100; dwell = 8'd5; en = 1'b1;
        @(negedge clk);
        chk("t6_sel0", 8'({s1, s0}), 8'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_sel",     8'({s1, s0}), 8'd0);
        chk("t6_rst_ocupado", 8'(ocupado),  8'd0);
        chk("t6_rst_dato",    8'(dato),     8'd0);
        chk("t6_rst_canal",   8'(canal),    8'd0);
        chk("t6_rst_valido",  8'(valido),   8'd0);
        @(negedge clk);
        mascara = 4'b1111; dwell = 8'd1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_restart_sel", 8'({s1, s0}), 8'd0);
        chk("t6_restart_ocu", 8'(ocupado),  8'd1);
        @(negedge clk);
        $display("t6 first sample: canal=%0d dato=%0d valido=%0b", canal, dato, valido);
        chk("t6_valido", 8'(valido), 8'd1);
        chk("t6_dato",   8'(dato),   8'd1);
        chk("t6_canal",  8'(canal),  8'd0);
        en = 1'b0;
        esperar_reposo("t6_idle_timeout");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/barrido_mux4.md
# barrido_mux4

Round-robin channel scanner that sits directly upstream of the 4:1 channel multiplexer (`mux4a1`). It drives the multiplexer's select lines `s0`/`s1` through the enabled channels, holding each one for a programmable dwell time. At the end of each dwell it registers the multiplexer output `F` together with the channel index and a one-cycle valid strobe, which serialises four parallel channels into one tagged sample stream.

## Interface
Parameters:
- `ancho`, default 4: channel data width; must match the `width` parameter of the `mux4a1` it drives.
- `DWELL_W`, default 8: width of the dwell-time input.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: scan enable.
- `mascara`, in, 4: channel enable mask; bit i enables channel i (0=A, 1=B, 2=C, 3=D).
- `dwell`, in, DWELL_W: cycles per channel; 0 is treated as 1.
- `F_in`, in, ancho: combinational output of `mux4a1`.
- `s0`, out, 1: select LSB to the mux; registered.
- `s1`, out, 1: select MSB to the mux; registered.
- `dato`, out, ancho: captured sample.
- `canal`, out, 2: channel index of `dato`.
- `valido`, out, 1: one-cycle strobe; `dato`/`canal` are new.
- `ocupado`, out, 1: high while not in REPOSO.

## Operation
- FSM has two states. REPOSO is idle. ESPERA is dwelling on one channel.
- Internal state:
  - `ptr[1:0]` holds the last channel visited.
  - `cnt[DWELL_W-1:0]` is the down-counter.
- Next-channel rule: from `ptr`, take the lowest-index enabled channel strictly after `ptr`, wrapping 3→0. If only `ptr` itself is enabled, the result is `ptr`.
- REPOSO → ESPERA when `en`=1 and `mascara`≠0 at a clock edge. On that edge:
  - `{s1,s0}` ← next channel.
  - `ptr` ← next channel.
  - `cnt` ← max(`dwell`,1)−1.
- In ESPERA, `cnt` decrements each cycle while `cnt`≠0.
- Capture edge is the edge at which `cnt`=0. On it:
  - `dato` ← `F_in`, `canal` ← `{s1,s0}`, `valido` ← 1.
  - If `en`=1 and `mascara`≠0: select the next channel and reload `cnt`, all on the same edge; stay in ESPERA.
  - Otherwise: go to REPOSO and set `{s1,s0}` ← 00.
- `valido` is 0 on every other edge.
- `mascara` and `dwell` are sampled only at selection edges. Changes mid-dwell do not affect the current channel.
- `en` deasserted mid-dwell does not truncate the dwell: the current capture completes, then the block goes to REPOSO.
- `dato` and `canal` hold their last values in REPOSO.

## Timing
- Reset (async assert, sync release) sets:
  - state=REPOSO, `s0`=`s1`=0, `dato`=0, `canal`=0, `valido`=0, `ocupado`=0, `cnt`=0.
  - `ptr`=3, so the first scan starts at the lowest enabled channel.
- Reset asserted mid-dwell: all outputs go to their reset values immediately. No capture occurs.
- Selection at edge e: `s` is valid from e, and `F_in` settles within the same cycle because the mux is combinational.
- Capture occurs at edge e+D, where D = max(`dwell`,1). `valido` is high for the cycle following e+D.
- Throughput: one sample per D cycles. With D=1, `valido` is continuously high.
- `ocupado` is 1 from the selection edge through the final capture edge. It falls on the edge that enters REPOSO.

## Structure
- Package `barrido_pkg` holds:
  - state encodings: REPOSO=1'b0, ESPERA=1'b1.
  - the constant `N_CANALES`=4.
  - the reset value of `ptr` (2'd3).
- One combinational sub-module, `siguiente_canal`:
  - inputs `ptr[1:0]`, `mascara[3:0]`.
  - outputs `sig[1:0]`, `hay` (= |mascara).
  - implements the wrap-around priority search.
- Top level holds the FSM, counter, and capture registers. The bench instantiates it with `mux4a1` (`width`=`ancho`).

## Test plan
1. A..D=1,2,3,4; `mascara`=1111; `dwell`=1; raise `en` → `valido` high every cycle; `dato`=1,2,3,4,1,…; `canal`=0,1,2,3,0,….
2. `mascara`=1010; `dwell`=3 → `{s1,s0}` alternates 01/11, each held 3 cycles; `valido` pulses every 3 cycles; `dato`=2,4,2,4.
3. `dwell`=0; `mascara`=0100 → identical to `dwell`=1; `canal` always 2, `dato` always 3, `valido` continuous.
4. `dwell`=5; drop `en` at cycle 2 of the dwell → capture still at cycle 5; then REPOSO, `{s1,s0}`=00, `ocupado`=0, no further `valido`.
5. `en`=1, `mascara`=0000 for 20 cycles → stays in REPOSO; `valido`=0, `ocupado`=0, `s`=00.
6. `rst_n` pulsed low asynchronously mid-dwell on channel 2 → outputs zero without waiting for a clock edge. After release with `mascara`=1111, the first capture is channel 0 with `dato`=1.
